async_fifo_pro: RTL and testbench

- Parametrised dual-clock FIFO and successor to the team's basic async FIFO. Used for UART packet byte transfer between the write (system) and read (baud/packet) clock domains.
- Adds configurable synchroniser depth, registered Gray pointers, registered full/empty, per-domain fill levels, programmable almost-full/almost-empty, and sticky overflow/underflow flags.
- Optional first-word-fall-through (FWFT) read mode.

---
 rtl/async_fifo_pro_pkg.sv | 26 ++
 rtl/async_fifo_pro_if.sv | 33 +++
 rtl/async_fifo_pro_cdc_sync_bus.sv | 30 +++
 rtl/async_fifo_pro.sv | 132 +++++++++++++
 tb/tb_async_fifo_pro.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/async_fifo_pro_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray/binary conversion and sync limits.
// Pure combinational functions; no latency of their own.
// No flow control here; callers size the results to their pointer width.
package async_fifo_pkg;

   // Fewer than two flops gives no meaningful metastability protection.
   localparam int MIN_SYNC_STAGES = 2;

   // Widest pointer the helpers handle; callers zero-extend in and truncate out.
   localparam int GRAY_MAX_W = 32;

   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b = g;
      for (int i = 1; i < GRAY_MAX_W; i++) begin
         b = b ^ (g >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/async_fifo_pro_if.sv
// Write/read handshake and status bundle of async_fifo_pro; clocks and reset stay outside.
// Wires only; no latency.
// Writer watches full, reader watches empty/data_valid; the FIFO never stalls either side.
interface async_fifo_pro_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic [DATA_WIDTH-1:0] data_in;
   logic                  write_en;
   logic                  full;
   logic                  almost_full;
   logic [ADDR_WIDTH:0]   wr_level;
   logic                  wr_overflow;
   logic                  read_en;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  data_valid;
   logic                  empty;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   rd_level;
   logic                  rd_underflow;

   modport master (
      output data_in, write_en, read_en,
      input  full, almost_full, wr_level, wr_overflow,
      input  data_out, data_valid, empty, almost_empty, rd_level, rd_underflow
   );

   modport slave (
      input  data_in, write_en, read_en,
      output full, almost_full, wr_level, wr_overflow,
      output data_out, data_valid, empty, almost_empty, rd_level, rd_underflow
   );
endinterface

// File: rtl/async_fifo_pro_cdc_sync_bus.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into clk.
// Latency: STAGES clk edges (clamped to at least MIN_SYNC_STAGES).
// No backpressure; samples d every clk edge, async reset to 0.
module cdc_sync_bus
   import async_fifo_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   localparam int N = (STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : STAGES;

   logic [WIDTH-1:0] sync_q [N];

   // Shift the incoming Gray value down the flop chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= d;
         for (int i = 1; i < N; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign q = sync_q[N-1];
endmodule

// File: rtl/async_fifo_pro.sv
// Dual-clock FIFO with registered Gray pointers, levels, thresholds and sticky error flags.
// Read data 1 rd_clk after read_en (or preloaded head word when ASYNC_FIFO_FWFT_EN is defined).
// Writes while full are dropped (wr_overflow), reads while empty are ignored (rd_underflow).
module async_fifo_pro
   import async_fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int FIFO_DEPTH    = 16,
   parameter int ADDR_WIDTH    = $clog2(FIFO_DEPTH),
   parameter int SYNC_STAGES   = 2,
   parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
   parameter int AEMPTY_THRESH = 2
) (
   input logic wr_clk,
   input logic rd_clk,
   input logic rst,
   async_fifo_pro_if.slave bus
);
   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] AFULL_LV  = PW'(AFULL_THRESH);
   localparam logic [PW-1:0] AEMPTY_LV = PW'(AEMPTY_THRESH);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

   // Write domain state
   logic [PW-1:0] wbin, wbin_next, wgray, wgray_next, rq, rq_bin, wr_level_next, wr_level_q;
   logic          wr_fire, full_q, afull_q, wr_ovf_q;

   // Read domain state
   logic [PW-1:0]         rbin, rbin_next, rgray, rgray_next, wq, wq_bin, rd_level_next, rd_level_q;
   logic                  rd_fire, ram_empty_q, dv_next, dv_q, aempty_q, rd_unf_q, underflow_evt;
   logic [DATA_WIDTH-1:0] dout_q;

   cdc_sync_bus #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_r2w (
      .clk(wr_clk), .rst(rst), .d(rgray), .q(rq)
   );

   cdc_sync_bus #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_w2r (
      .clk(rd_clk), .rst(rst), .d(wgray), .q(wq)
   );

   // Next write pointer and occupancy as seen from the write side.
   always_comb begin
      wr_fire       = bus.write_en && !full_q;
      wbin_next     = wbin + PW'(wr_fire);
      wgray_next    = PW'(bin2gray(GRAY_MAX_W'(wbin_next)));
      rq_bin        = PW'(gray2bin(GRAY_MAX_W'(rq)));
      wr_level_next = wbin_next - rq_bin;
   end

   // Write-domain registers; full compares against the read pointer with its top two Gray bits inverted.
   always_ff @(posedge wr_clk or posedge rst) begin
      if (rst) begin
         wbin       <= '0;
         wgray      <= '0;
         full_q     <= 1'b0;
         afull_q    <= 1'b0;
         wr_level_q <= '0;
         wr_ovf_q   <= 1'b0;
      end else begin
         wbin       <= wbin_next;
         wgray      <= wgray_next;
         full_q     <= (wgray_next == {~rq[PW-1:PW-2], rq[PW-3:0]});
         afull_q    <= (wr_level_next >= AFULL_LV);
         wr_level_q <= wr_level_next;
         if (bus.write_en && full_q) wr_ovf_q <= 1'b1;
      end
   end

   // Storage array; contents deliberately survive reset since pointers discard them.
   always_ff @(posedge wr_clk) begin
      if (wr_fire) mem[wbin[ADDR_WIDTH-1:0]] <= bus.data_in;
   end

   // Pop decision and next read pointer; FWFT refills the output register whenever it frees up.
   always_comb begin
`ifdef ASYNC_FIFO_FWFT_EN
      rd_fire       = (!dv_q || bus.read_en) && !ram_empty_q;
      dv_next       = rd_fire || (dv_q && !bus.read_en);
      underflow_evt = bus.read_en && !dv_q;
`else
      rd_fire       = bus.read_en && !ram_empty_q;
      dv_next       = rd_fire;
      underflow_evt = bus.read_en && ram_empty_q;
`endif
      rbin_next     = rbin + PW'(rd_fire);
      rgray_next    = PW'(bin2gray(GRAY_MAX_W'(rbin_next)));
      wq_bin        = PW'(gray2bin(GRAY_MAX_W'(wq)));
      rd_level_next = wq_bin - rbin_next;
`ifdef ASYNC_FIFO_FWFT_EN
      rd_level_next = rd_level_next + PW'(dv_next);
`endif
   end

   // Read-domain registers and output data register.
   always_ff @(posedge rd_clk or posedge rst) begin
      if (rst) begin
         rbin        <= '0;
         rgray       <= '0;
         ram_empty_q <= 1'b1;
         aempty_q    <= 1'b1;
         rd_level_q  <= '0;
         dv_q        <= 1'b0;
         rd_unf_q    <= 1'b0;
         dout_q      <= '0;
      end else begin
         rbin        <= rbin_next;
         rgray       <= rgray_next;
         ram_empty_q <= (rgray_next == wq);
         aempty_q    <= (rd_level_next <= AEMPTY_LV);
         rd_level_q  <= rd_level_next;
         dv_q        <= dv_next;
         if (rd_fire) dout_q <= mem[rbin[ADDR_WIDTH-1:0]];
         if (underflow_evt) rd_unf_q <= 1'b1;
      end
   end

   assign bus.full         = full_q;
   assign bus.almost_full  = afull_q;
   assign bus.wr_level     = wr_level_q;
   assign bus.wr_overflow  = wr_ovf_q;
   assign bus.data_out     = dout_q;
   assign bus.data_valid   = dv_q;
`ifdef ASYNC_FIFO_FWFT_EN
   assign bus.empty        = !dv_q;
`else
   assign bus.empty        = ram_empty_q;
`endif
   assign bus.almost_empty = aempty_q;
   assign bus.rd_level     = rd_level_q;
   assign bus.rd_underflow = rd_unf_q;
endmodule

// File: tb/tb_async_fifo_pro.sv
// Self-checking bench for async_fifo_pro: fill/drain, streaming at two clock ratios,
// single-word latency, mid-burst reset, and the FWFT head-word behaviour when enabled.
`timescale 1ns/1ps
module tb_async_fifo_pro;
   localparam int DW = 8;
   localparam int DEPTH = 16;
   localparam int AW = 4;
   localparam int SS = 2;
   localparam logic [24:0] RESET_SNAP = {1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 8'h00, 1'b0, 1'b0};

   logic wr_clk = 1'b0;
   logic rd_clk = 1'b0;
   logic rst = 1'b1;
   real  wr_half = 5.0;
   real  rd_half = 13.514;

   always #(wr_half) wr_clk = ~wr_clk;
   always #(rd_half) rd_clk = ~rd_clk;

   async_fifo_pro_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) fif ();

   async_fifo_pro #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
      .wr_clk(wr_clk), .rd_clk(rd_clk), .rst(rst), .bus(fif)
   );

   int n_vec = 0;
   int n_fail = 0;
   logic [DW-1:0] sb [$];

   function automatic logic [24:0] snap();
      return {fif.full, fif.almost_full, fif.wr_level, fif.wr_overflow, fif.empty, fif.almost_empty,
              fif.rd_level, fif.data_out, fif.data_valid, fif.rd_underflow};
   endfunction

   task automatic do_reset();
      fif.write_en = 1'b0;
      fif.read_en  = 1'b0;
      fif.data_in  = '0;
      rst = 1'b1;
      repeat (3) @(posedge rd_clk);
      #2 rst = 1'b0;
      repeat (2) @(posedge rd_clk);
      @(posedge wr_clk); #1;
      sb.delete();
   endtask

   task automatic write_word(input logic [DW-1:0] d);
      fif.data_in  = d;
      fif.write_en = 1'b1;
      @(posedge wr_clk); #1;
      fif.write_en = 1'b0;
   endtask

   // Reader: request whenever not empty, score every data_valid against the queue head.
   task automatic drain(input int n_words, input int budget);
      int got = 0;
      int cyc = 0;
      logic [DW-1:0] exp;
      while (got < n_words && cyc < budget) begin
         fif.read_en = !fif.empty;
         @(posedge rd_clk); #1;
         cyc++;
         if (fif.data_valid === 1'b1) begin
            got++;
            n_vec++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL drain_extra: got data 0x%02h, none expected", fif.data_out);
            end else begin
               exp = sb.pop_front();
               if (fif.data_out !== exp) begin
                  n_fail++;
                  $display("FAIL drain_data: got 0x%02h want 0x%02h", fif.data_out, exp);
               end
            end
         end
      end
      fif.read_en = 1'b0;
      n_vec++;
      if (got != n_words) begin
         n_fail++;
         $display("FAIL drain_timeout: got %0d words want %0d", got, n_words);
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++;
      if (snap() !== RESET_SNAP) begin
         n_fail++;
         $display("FAIL reset_state: got %h want %h", snap(), RESET_SNAP);
      end
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         sb.push_back(DW'(i));
         write_word(DW'(i));
         n_vec++;
         if (fif.wr_level !== 5'(i + 1) || fif.almost_full !== (i + 1 >= DEPTH - 2) || fif.full !== (i + 1 == DEPTH)) begin
            n_fail++;
            $display("FAIL fill_flags[%0d]: got lvl=%0d af=%b f=%b want lvl=%0d af=%b f=%b", i, fif.wr_level,
                     fif.almost_full, fif.full, i + 1, (i + 1 >= DEPTH - 2), (i + 1 == DEPTH));
         end
      end
      write_word(8'hAA);
      n_vec++;
      if (fif.wr_overflow !== 1'b1 || fif.full !== 1'b1 || fif.wr_level !== 5'd16) begin
         n_fail++;
         $display("FAIL overflow: got ovf=%b f=%b lvl=%0d want 1 1 16", fif.wr_overflow, fif.full, fif.wr_level);
      end
   endtask

   task automatic test_drain();
      repeat (SS + 2) @(posedge rd_clk);
      #1;
      drain(DEPTH, 200);
      n_vec++;
      if (fif.empty !== 1'b1 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain_empty: got empty=%b left=%0d want 1 0", fif.empty, sb.size());
      end
      fif.read_en = 1'b1;
      @(posedge rd_clk); #1;
      fif.read_en = 1'b0;
      n_vec++;
      if (fif.rd_underflow !== 1'b1 || fif.data_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL underflow: got unf=%b dv=%b want 1 0", fif.rd_underflow, fif.data_valid);
      end
   endtask

   task automatic stream(input int n_words);
      fork
         begin
            int i = 0;
            while (i < n_words) begin
               if (fif.full === 1'b0) begin
                  fif.data_in  = DW'(i);
                  fif.write_en = 1'b1;
                  sb.push_back(DW'(i));
                  i++;
               end else begin
                  fif.write_en = 1'b0;
               end
               @(posedge wr_clk); #1;
            end
            fif.write_en = 1'b0;
         end
         drain(n_words, n_words * 8 + 100);
      join
      n_vec++;
      if (fif.wr_overflow !== 1'b0 || fif.rd_underflow !== 1'b0 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL stream_flags: got ovf=%b unf=%b left=%0d want 0 0 0", fif.wr_overflow, fif.rd_underflow, sb.size());
      end
   endtask

   task automatic test_back_to_back();
      wr_half = 5.0;
      rd_half = 6.849;
      do_reset();
      stream(1000);
      wr_half = 6.849;
      rd_half = 5.0;
      repeat (4) @(posedge wr_clk);
      #1;
      stream(1000);
      rd_half = 13.514;
      wr_half = 5.0;
   endtask

   task automatic test_single();
      int k = 0;
      do_reset();
      sb.push_back(8'h5A);
      write_word(8'h5A);
      while (fif.empty === 1'b1 && k < SS + 2) begin
         @(posedge rd_clk); #1;
         k++;
      end
      n_vec++;
      if (fif.empty !== 1'b0) begin
         n_fail++;
         $display("FAIL single_latency: empty still %b after %0d rd edges, want 0", fif.empty, k);
      end
      n_vec++;
      if (fif.rd_level !== 5'd1 || fif.almost_empty !== 1'b1) begin
         n_fail++;
         $display("FAIL single_level: got lvl=%0d ae=%b want 1 1", fif.rd_level, fif.almost_empty);
      end
      drain(1, 20);
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int i = 0; i < 7; i++) begin
         fif.data_in  = DW'(8'h30 + i);
         fif.write_en = 1'b1;
         @(posedge wr_clk); #1;
      end
      n_vec++;
      if (fif.wr_level !== 5'd7) begin
         n_fail++;
         $display("FAIL midrst_pre: got lvl=%0d want 7", fif.wr_level);
      end
      #3 rst = 1'b1;
      #1;
      n_vec++;
      if (snap() !== RESET_SNAP) begin
         n_fail++;
         $display("FAIL midrst_async: got %h want %h", snap(), RESET_SNAP);
      end
      do_reset();
      sb.push_back(8'h77);
      write_word(8'h77);
      repeat (SS + 3) @(posedge rd_clk);
      #1;
      drain(1, 20);
      repeat (SS + 3) @(posedge rd_clk);
      #1;
      n_vec++;
      if (fif.empty !== 1'b1 || fif.rd_level !== 5'd0) begin
         n_fail++;
         $display("FAIL midrst_stale: got empty=%b lvl=%0d want 1 0", fif.empty, fif.rd_level);
      end
   endtask

`ifdef ASYNC_FIFO_FWFT_EN
   task automatic test_fwft();
      logic [DW-1:0] exp;
      do_reset();
      sb.push_back(8'h11);
      write_word(8'h11);
      sb.push_back(8'h22);
      write_word(8'h22);
      repeat (SS + 4) @(posedge rd_clk);
      #1;
      exp = sb.pop_front();
      n_vec++;
      if (fif.data_out !== exp || fif.data_valid !== 1'b1 || fif.empty !== 1'b0 || fif.rd_level !== 5'd2) begin
         n_fail++;
         $display("FAIL fwft_head: got d=0x%02h dv=%b e=%b lvl=%0d want 0x%02h 1 0 2", fif.data_out,
                  fif.data_valid, fif.empty, fif.rd_level, exp);
      end
      fif.read_en = 1'b1;
      @(posedge rd_clk); #1;
      fif.read_en = 1'b0;
      exp = sb.pop_front();
      n_vec++;
      if (fif.data_out !== exp || fif.data_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL fwft_next: got d=0x%02h dv=%b want 0x%02h 1", fif.data_out, fif.data_valid, exp);
      end
      fif.read_en = 1'b1;
      @(posedge rd_clk); #1;
      fif.read_en = 1'b0;
      n_vec++;
      if (fif.data_valid !== 1'b0 || fif.empty !== 1'b1 || fif.rd_underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL fwft_drained: got dv=%b e=%b unf=%b want 0 1 0", fif.data_valid, fif.empty, fif.rd_underflow);
      end
   endtask
`endif

   initial begin
      test_reset();
`ifdef ASYNC_FIFO_FWFT_EN
      test_fwft();
`else
      test_fill();
      test_drain();
      test_back_to_back();
      test_single();
      test_mid_reset();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
